// File: rtl/i2c_target_if.sv
// Local-side interface of the I2C target: received bytes, transmit bytes, status strobes.
// Handshake: rx_valid and tx_req are single-clk pulses with no back-pressure; rx_data is valid in the
// rx_valid cycle and held until the next one; tx_data must be stable from tx_req+1 clk until the next SCL fall.
interface i2c_target_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       rw_mode;
  logic       busy;
  logic       stop_det;
  logic [2:0] state_dbg;

  modport slave (
    output rx_data, rx_valid, tx_req, rw_mode, busy, stop_det, state_dbg,
    input  tx_data
  );

  modport master (
    input  rx_data, rx_valid, tx_req, rw_mode, busy, stop_det, state_dbg,
    output tx_data
  );
endinterface

// File: rtl/i2c_target.sv
// I2C target responder: oversampled SCL/SDA, START/STOP detection, 7-bit address match,
// byte receive/transmit with open-drain SDA. Never drives SCL.
module i2c_target #(
   parameter logic [6:0] TARGET_ADDR = 7'h50,
   parameter int         SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic scl,
   inout  wire  sda,
   i2c_target_if.slave lcl
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_RX_BYTE,
      ST_RX_ACK, ST_TX_BYTE, ST_TX_ACK, ST_WAIT_STOP
   } state_e;

   logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
   logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
   logic                   scl_hist_q, scl_hist_d;
   logic                   sda_hist_q, sda_hist_d;

   state_e      state_q, state_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic        sda_oe_q, sda_oe_d;
   logic [7:0]  rx_data_q, rx_data_d;
   logic        rx_valid_q, rx_valid_d;
   logic        tx_req_q, tx_req_d;
   logic        rw_mode_q, rw_mode_d;
   logic        busy_q, busy_d;
   logic        stop_det_q, stop_det_d;

   logic       sda_in, scl_s, sda_s;
   logic       scl_rise, scl_fall, start_cond, stop_cond;
   logic [7:0] byte_in;

   // Open-drain: only ever pull low; the reset path clears sda_oe_q asynchronously.
   assign sda    = sda_oe_q ? 1'b0 : 1'bz;
   assign sda_in = sda;

   assign scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
   assign sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
   assign scl_s      = scl_sync_q[SYNC_STAGES-1];
   assign sda_s      = sda_sync_q[SYNC_STAGES-1];
   assign scl_hist_d = scl_s;
   assign sda_hist_d = sda_s;

   assign scl_rise   = scl_s & ~scl_hist_q;
   assign scl_fall   = ~scl_s & scl_hist_q;
   assign start_cond = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
   assign stop_cond  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;
   assign byte_in    = {shift_q[6:0], sda_s};

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      sda_oe_d   = sda_oe_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      tx_req_d   = 1'b0;
      rw_mode_d  = rw_mode_q;
      busy_d     = busy_q;
      stop_det_d = 1'b0;
      if (stop_cond) begin
         state_d    = ST_IDLE;
         sda_oe_d   = 1'b0;
         busy_d     = 1'b0;
         stop_det_d = 1'b1;
         bit_cnt_d  = 4'd0;
      end else if (start_cond) begin
         state_d   = ST_ADDR;
         sda_oe_d  = 1'b0;
         bit_cnt_d = 4'd7;
      end else begin
         unique case (state_q)
            ST_ADDR: if (scl_rise) begin
               shift_d = byte_in;
               if (bit_cnt_q == 4'd0) begin
                  if (byte_in[7:1] == TARGET_ADDR) begin
                     rw_mode_d = byte_in[0];
                     busy_d    = 1'b1;
                     bit_cnt_d = 4'd8;
                     state_d   = ST_ADDR_ACK;
                  end else begin
                     busy_d  = 1'b0;
                     state_d = ST_IDLE;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q - 4'd1;
               end
            end
            // First fall starts the ACK, the second ends it; sda_oe_q tells them apart.
            ST_ADDR_ACK: begin
               if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = 1'b1;
                  end else if (rw_mode_q) begin
                     shift_d   = lcl.tx_data;
                     sda_oe_d  = ~lcl.tx_data[7];
                     bit_cnt_d = 4'd7;
                     state_d   = ST_TX_BYTE;
                  end else begin
                     sda_oe_d  = 1'b0;
                     bit_cnt_d = 4'd7;
                     state_d   = ST_RX_BYTE;
                  end
               end else if (scl_rise && sda_oe_q && rw_mode_q) begin
                  tx_req_d = 1'b1;
               end
            end
            ST_RX_BYTE: if (scl_rise) begin
               shift_d = byte_in;
               if (bit_cnt_q == 4'd0) begin
                  rx_data_d  = byte_in;
                  rx_valid_d = 1'b1;
                  bit_cnt_d  = 4'd8;
                  state_d    = ST_RX_ACK;
               end else begin
                  bit_cnt_d = bit_cnt_q - 4'd1;
               end
            end
            ST_RX_ACK: if (scl_fall) begin
               if (!sda_oe_q) begin
                  sda_oe_d = 1'b1;
               end else begin
                  sda_oe_d  = 1'b0;
                  bit_cnt_d = 4'd7;
                  state_d   = ST_RX_BYTE;
               end
            end
            ST_TX_BYTE: if (scl_fall) begin
               if (bit_cnt_q == 4'd0) begin
                  sda_oe_d  = 1'b0;
                  bit_cnt_d = 4'd8;
                  state_d   = ST_TX_ACK;
               end else begin
                  shift_d   = {shift_q[6:0], 1'b0};
                  sda_oe_d  = ~shift_q[6];
                  bit_cnt_d = bit_cnt_q - 4'd1;
               end
            end
            // Entered on a fall, so the only fall seen here follows an ACKed rise.
            ST_TX_ACK: begin
               if (scl_rise) begin
                  if (!sda_s) begin
                     tx_req_d = 1'b1;
                  end else begin
                     sda_oe_d = 1'b0;
                     state_d  = ST_WAIT_STOP;
                  end
               end else if (scl_fall) begin
                  shift_d   = lcl.tx_data;
                  sda_oe_d  = ~lcl.tx_data[7];
                  bit_cnt_d = 4'd7;
                  state_d   = ST_TX_BYTE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_hist_q <= 1'b1;
         sda_hist_q <= 1'b1;
         state_q    <= ST_IDLE;
         bit_cnt_q  <= 4'd0;
         shift_q    <= 8'd0;
         sda_oe_q   <= 1'b0;
         rx_data_q  <= 8'd0;
         rx_valid_q <= 1'b0;
         tx_req_q   <= 1'b0;
         rw_mode_q  <= 1'b0;
         busy_q     <= 1'b0;
         stop_det_q <= 1'b0;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_hist_q <= scl_hist_d;
         sda_hist_q <= sda_hist_d;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         sda_oe_q   <= sda_oe_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         tx_req_q   <= tx_req_d;
         rw_mode_q  <= rw_mode_d;
         busy_q     <= busy_d;
         stop_det_q <= stop_det_d;
      end
   end

   assign lcl.rx_data   = rx_data_q;
   assign lcl.rx_valid  = rx_valid_q;
   assign lcl.tx_req    = tx_req_q;
   assign lcl.rw_mode   = rw_mode_q;
   assign lcl.busy      = busy_q;
   assign lcl.stop_det  = stop_det_q;
   assign lcl.state_dbg = state_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-level I2C master model, transaction-level reference model,
// rx scoreboard queue and tx_data responder driven from the local-side strobes.
module tb_i2c_target;

  localparam logic [6:0] TADDR = 7'h50;
  localparam int Q = 4;  // quarter SCL period in clk cycles (SCL = clk/16)

  logic clk = 1'b0;
  logic rst;
  logic scl;
  logic m_sda_low;
  wire  sda;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_target_if bus_if ();

  i2c_target #(.TARGET_ADDR(TADDR), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .scl (scl),
    .sda (sda),
    .lcl (bus_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_rx = 0;
  int n_req = 0;
  int n_stop = 0;
  int stop_exp = 0;
  logic [7:0] exp_rx_q[$];
  logic [7:0] tx_src_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor / scoreboard: pops expected rx bytes, feeds tx bytes, counts strobes.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus_if.rx_valid) begin
          n_rx++;
          if (exp_rx_q.size() == 0) begin
            check("rx_unexpected", {24'd0, bus_if.rx_data}, 32'hFFFF_FFFF);
          end else begin
            e = exp_rx_q.pop_front();
            check("rx_data", {24'd0, bus_if.rx_data}, {24'd0, e});
          end
        end
        if (bus_if.rx_valid && bus_if.tx_req)
          check("rx_tx_overlap", 32'd1, 32'd0);
        if (bus_if.tx_req) begin
          n_req++;
          if (tx_src_q.size() == 0) begin
            check("tx_req_unexpected", 32'd1, 32'd0);
          end else begin
            bus_if.tx_data = tx_src_q.pop_front();
          end
        end
        if (bus_if.stop_det) n_stop++;
      end
    end
  end

  // Bit-level master model; SCL low phase is 2*Q, SDA changes mid-low.
  task automatic bit_out(input logic b);
    m_sda_low = ~b;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(2 * Q);
    scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic bit_in(output logic b);
    m_sda_low = 1'b0;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    b = sda;
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    m_sda_low = 1'b1;
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    m_sda_low = 1'b0;
    stop_exp++;
    wait_clk(2 * Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) bit_out(d[i]);
    bit_in(ack);
  endtask

  task automatic rd_byte(output logic [7:0] d, input logic master_ack);
    logic b;
    d = 8'd0;
    for (int i = 0; i < 8; i++) begin
      bit_in(b);
      d = {d[6:0], b};
    end
    bit_out(~master_ack);
  endtask

  // Transaction-level reference: a matching address is ACKed, written bytes reappear on rx_data
  // and are ACKed, read bytes come from tx_data with one tx_req per byte; otherwise the bus
  // floats high (NACK, 0xFF read) and the local side sees nothing.
  task automatic xfer(input logic [6:0] a, input logic rw, input logic [7:0] data[$], input bit end_stop);
    logic ack;
    logic [7:0] got;
    bit match;
    int req0;
    match = (a == TADDR);
    i2c_start();
    req0 = n_req;
    if (match && rw) foreach (data[i]) tx_src_q.push_back(data[i]);
    wr_byte({a, rw}, ack);
    check("addr_ack", {31'd0, ack}, {31'd0, !match});
    check("busy_after_addr", {31'd0, bus_if.busy}, {31'd0, match});
    if (match) check("rw_mode", {31'd0, bus_if.rw_mode}, {31'd0, rw});
    check("tx_req_at_addr", n_req - req0, (match && rw) ? 1 : 0);
    foreach (data[i]) begin
      if (!rw) begin
        if (match) exp_rx_q.push_back(data[i]);
        wr_byte(data[i], ack);
        check("data_ack", {31'd0, ack}, {31'd0, !match});
      end else begin
        rd_byte(got, i != data.size() - 1);
        check("rd_byte", {24'd0, got}, match ? {24'd0, data[i]} : 32'hFF);
      end
    end
    check("tx_req_count", n_req - req0, (match && rw) ? data.size() : 0);
    if (end_stop) begin
      i2c_stop();
      check("busy_after_stop", {31'd0, bus_if.busy}, 32'd0);
      check("rx_pending", exp_rx_q.size(), 0);
      check("stop_det_count", n_stop, stop_exp);
      check("sda_released", {31'd0, sda}, 32'd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"}, {24'd0, bus_if.rx_data}, 32'd0);
    check({tag, "_rx_valid"}, {31'd0, bus_if.rx_valid}, 32'd0);
    check({tag, "_tx_req"}, {31'd0, bus_if.tx_req}, 32'd0);
    check({tag, "_rw_mode"}, {31'd0, bus_if.rw_mode}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus_if.busy}, 32'd0);
    check({tag, "_stop_det"}, {31'd0, bus_if.stop_det}, 32'd0);
    check({tag, "_sda"}, {31'd0, sda}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    logic ack;
    logic [6:0] a;
    logic rw;
    int rx0;

    rst = 1'b1;
    scl = 1'b1;
    m_sda_low = 1'b0;
    bus_if.tx_data = 8'h00;
    wait_clk(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_clk(4);

    q.delete(); q.push_back(8'hA5); q.push_back(8'h3C);
    xfer(TADDR, 1'b0, q, 1);

    q.delete(); q.push_back(8'h12); q.push_back(8'h34);
    xfer(7'h51, 1'b0, q, 1);

    q.delete(); q.push_back(8'h96); q.push_back(8'h0F);
    xfer(TADDR, 1'b1, q, 1);

    q.delete(); q.push_back(8'h11);
    xfer(TADDR, 1'b0, q, 0);
    q.delete(); q.push_back(8'($urandom_range(0, 255)));
    xfer(TADDR, 1'b1, q, 1);

    // STOP in the middle of a data byte.
    i2c_start();
    wr_byte({TADDR, 1'b0}, ack);
    check("mid_stop_addr_ack", {31'd0, ack}, 32'd0);
    rx0 = n_rx;
    for (int i = 0; i < 4; i++) bit_out(1'($urandom_range(0, 1)));
    i2c_stop();
    check("mid_stop_no_rx", n_rx, rx0);
    check("mid_stop_busy", {31'd0, bus_if.busy}, 32'd0);
    check("mid_stop_sda", {31'd0, sda}, 32'd1);
    check("mid_stop_det", n_stop, stop_exp);

    // Reset while the address ACK is being driven.
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_out(TADDR_bit(i));
    m_sda_low = 1'b0;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(2);
    check("ack_driven_before_rst", {31'd0, sda}, 32'd0);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    wait_clk(3);
    rst = 1'b0;
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(Q);
    q.delete(); q.push_back(8'($urandom_range(0, 255)));
    xfer(TADDR, 1'b0, q, 1);

    for (int t = 0; t < 14; t++) begin
      a = ($urandom_range(0, 2) != 0) ? TADDR : 7'($urandom_range(0, 127));
      rw = 1'($urandom_range(0, 1));
      q.delete();
      for (int k = 0; k < $urandom_range(1, 3); k++) q.push_back(8'($urandom_range(0, 255)));
      xfer(a, rw, q, 1);
    end

    wait_clk(8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  function automatic logic TADDR_bit(input int i);
    logic [7:0] w;
    w = {TADDR, 1'b0};
    return w[i];
  endfunction

endmodule
